jtriders_objsort: RTL and testbench
===================================

JTRIDERS_OBJSORT -- requirements
Module: jtriders_objsort

Interface
REQ-001 SHALL have parameter OBJW, default 7, object index width (2^OBJW objects scanned).
REQ-002 SHALL have parameter LVLW, default 3, priority level index width (2^LVLW levels).
REQ-003 SHALL have parameter STRW, default 3, log2 of object stride in 16-bit words.
REQ-004 SHALL have ports: clk in 1 system clock; rstn in 1 reset, synchronous, active-low; cen in 1 DMA step enable.
REQ-005 SHALL have CPU ports: cs in 1; we in 1; addr in 3 (word select); dsn in 2 byte strobes, active low; din in 16; dout out 16 register read data; irqn out 1 done interrupt, active low.
REQ-006 SHALL have bus ports: BRn out 1; BGn in 1; BGACKn out 1; dma_addr out 23 word address; dma_din in 16; dma_dout out 16; dma_we out 1; dma_dsn out 2; bus_busy in 1 access not complete.

Function
REQ-007 SHALL decode CPU writes (cs&we, dsn byte-gated): addr0 CTRL {bit0 start, bit1 onehot, bit2 descend, bit3 irqen}; addr1 SRC base; addr2 DST base; addr3 FIELD {bits[STRW-1:0] word offset, bit8 high-byte select}.
REQ-008 SHALL return on read of addr0 STATUS {bit15 busy, bit14 done, bits[OBJW:0] count}; addr1..3 return stored values; others 0xFFFF; dout registered, 1-cycle latency.
REQ-009 SHALL form addresses as SRC<<STRW + idx<<STRW + offset for reads and DST + n for writes, 23-bit modulo wrap.
REQ-010 SHALL run states IDLE, REQ, RD, CHK, WR, NXT, TERM, DONE.
REQ-011 IDLE: CTRL write with bit0=1 -> REQ, BRn=0, count=0, idx=0, level=0 (or 2^LVLW-1 if descend), done=0, irqn=1.
REQ-012 REQ: BGn=0 sampled while BRn=0 -> BRn=1, BGACKn=0, RD next cycle; BGACKn stays 0 until DONE.
REQ-013 RD: dma_addr=object field address, dma_we=0, dma_dsn=00; on cen with bus_busy=0 latch selected byte -> CHK.
REQ-014 CHK (one cycle, no cen needed): match if byte==level (binary) or byte==1<<level (onehot, level>7 never matches); match -> WR, else NXT.
REQ-015 WR: dma_addr=DST+count, dma_dout=idx zero-extended, dma_we=1, dma_dsn=00; on cen with bus_busy=0 count+=1 -> NXT.
REQ-016 NXT: idx+=1 -> RD; if idx all-ones: idx=0 and level steps (+1 ascend, -1 descend); after final level -> TERM.
REQ-017 TERM: if count<2^OBJW write 0xFFFF at DST+count using WR handshake, count unchanged; else skip; -> DONE.
REQ-018 DONE: BGACKn=1, busy=0, done=1, irqn=0 if irqen; -> IDLE.
REQ-019 irqn SHALL return to 1 on STATUS read or any CTRL write.
REQ-020 Start writes while busy SHALL be ignored; SRC/DST/FIELD writes while busy SHALL be stored but take effect next run.
REQ-021 cen low or bus_busy high SHALL hold all bus outputs stable; dma_we=0 outside WR/TERM.
REQ-022 Duplicate priority values SHALL be written once per matching level only; count saturates at 2^OBJW.

Reset
REQ-023 rstn=0 at posedge clk SHALL force IDLE, BRn=1, BGACKn=1, irqn=1, dma_we=0, dma_dsn=11, dma_addr=0, dout=0, all registers 0, count=0, done=0.
REQ-024 Reset mid-run SHALL abort immediately with bus released on the next edge; no further writes.

Verification
REQ-025 Defaults, binary ascend, objects 0..127 field=idx&7, cen=1, bus_busy=0 -> 128 writes, DST list 0,8,16..120,1,9..127, no terminator, count=128, irqn=0 with irqen.
REQ-026 Onehot, only obj5 field=0x04, obj2 field=0x01 -> writes DST+0=2, DST+1=5, DST+2=0xFFFF, count=2.
REQ-027 Descend, obj3=7, obj9=0 -> DST+0=3, DST+1=9, DST+2=0xFFFF.
REQ-028 BGn held 1 for 50 cycles after start -> BRn=0, BGACKn=1, no bus activity; BGn=0 -> run proceeds.
REQ-029 bus_busy toggled randomly, cen=1-in-4 -> identical DST contents to REQ-025; outputs stable while stalled.
REQ-030 rstn=0 during WR -> next edge BGACKn=1, dma_we=0, STATUS reads 0; restart completes normally.

Source files
------------

// File: rtl/jtriders_objsort.sv
// Object priority sorter: scans an object table over the bus once per priority
// level and writes the matching object indices to a destination list, 0xFFFF-terminated.
module jtriders_objsort #(
  parameter int OBJW = 7,
  parameter int LVLW = 3,
  parameter int STRW = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cen,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [1:0]  dsn,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        irqn,
  output logic        BRn,
  input  logic        BGn,
  output logic        BGACKn,
  output logic [22:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic [15:0] dma_dout,
  output logic        dma_we,
  output logic [1:0]  dma_dsn,
  input  logic        bus_busy
);
  localparam int CW = OBJW + 1;

  typedef enum logic [2:0] {IDLE, REQ, RD, CHK, WR, NXT, TERM, DONE} state_t;
  state_t state, state_nx;

  // CPU-visible registers; a run works from the run_* copies taken at start
  logic [15:0]     src_r, dst_r, fld_r;
  logic [15:0]     run_src, run_dst;
  logic [STRW-1:0] run_off;
  logic            run_hi, run_onehot, run_descend, run_irqen;

  logic [OBJW-1:0] idx;
  logic [LVLW-1:0] level;
  logic [CW-1:0]   count;
  logic [7:0]      sel_byte;
  logic            done_r;

  logic        wr, rd, step, start, busy, full, last_idx, last_lvl, hit;
  logic [22:0] rd_addr, wr_addr;
  logic [15:0] rd_data, lvl16;

  function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] nv,
                                         input logic [1:0] ds);
    return {ds[1] ? old[15:8] : nv[15:8], ds[0] ? old[7:0] : nv[7:0]};
  endfunction

  assign wr       = cs & we;
  assign rd       = cs & ~we;
  assign step     = cen & ~bus_busy;
  assign start    = wr && (addr == 3'd0) && !dsn[0] && din[0] && (state == IDLE);
  assign busy     = (state != IDLE) && (state != DONE);
  assign full     = count[OBJW];
  assign last_idx = &idx;
  assign last_lvl = run_descend ? (level == '0) : (&level);

  // onehot compare only exists for levels that fit in a byte
  assign lvl16 = 16'(level);
  assign hit   = run_onehot ? ((lvl16 < 16'd8) && (sel_byte == (8'd1 << level)))
                            : (16'(sel_byte) == lvl16);

  assign rd_addr = (23'(run_src) << STRW) + (23'(idx) << STRW) + 23'(run_off);
  assign wr_addr = 23'(run_dst) + 23'(count);

  always_comb begin
    rd_data = 16'hFFFF;
    case (addr)
      3'd0: begin
        rd_data         = '0;
        rd_data[15]     = busy;
        rd_data[14]     = done_r;
        rd_data[OBJW:0] = count;
      end
      3'd1:    rd_data = src_r;
      3'd2:    rd_data = dst_r;
      3'd3:    rd_data = fld_r;
      default: rd_data = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Bus outputs depend only on registered state, so a stalled access holds them
  always_comb begin
    state_nx = state;
    dma_addr = '0;
    dma_dout = '0;
    dma_we   = 1'b0;
    dma_dsn  = 2'b11;
    case (state)
      IDLE: if (start) state_nx = REQ;
      REQ:  if (!BGn && !BRn) state_nx = RD;
      RD: begin
        dma_addr = rd_addr;
        dma_dsn  = 2'b00;
        if (step) state_nx = CHK;
      end
      CHK: state_nx = (hit && !full) ? WR : NXT;
      WR: begin
        dma_addr = wr_addr;
        dma_dout = 16'(idx);
        dma_we   = 1'b1;
        dma_dsn  = 2'b00;
        if (step) state_nx = NXT;
      end
      NXT: state_nx = (last_idx && last_lvl) ? TERM : RD;
      TERM: begin
        if (full) begin
          state_nx = DONE;
        end else begin
          dma_addr = wr_addr;
          dma_dout = 16'hFFFF;
          dma_we   = 1'b1;
          dma_dsn  = 2'b00;
          if (step) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      src_r       <= '0;
      dst_r       <= '0;
      fld_r       <= '0;
      run_src     <= '0;
      run_dst     <= '0;
      run_off     <= '0;
      run_hi      <= 1'b0;
      run_onehot  <= 1'b0;
      run_descend <= 1'b0;
      run_irqen   <= 1'b0;
      idx         <= '0;
      level       <= '0;
      count       <= '0;
      sel_byte    <= '0;
      done_r      <= 1'b0;
      irqn        <= 1'b1;
      BRn         <= 1'b1;
      BGACKn      <= 1'b1;
      dout        <= '0;
    end else begin
      if (wr) begin
        case (addr)
          3'd1:    src_r <= bmerge(src_r, din, dsn);
          3'd2:    dst_r <= bmerge(dst_r, din, dsn);
          3'd3:    fld_r <= bmerge(fld_r, din, dsn);
          default: ;
        endcase
      end
      if (rd) dout <= rd_data;
      if ((wr || rd) && addr == 3'd0) irqn <= 1'b1;

      case (state)
        IDLE: if (start) begin
          BRn         <= 1'b0;
          count       <= '0;
          idx         <= '0;
          level       <= din[2] ? '1 : '0;
          done_r      <= 1'b0;
          run_src     <= src_r;
          run_dst     <= dst_r;
          run_off     <= fld_r[STRW-1:0];
          run_hi      <= fld_r[8];
          run_onehot  <= din[1];
          run_descend <= din[2];
          run_irqen   <= din[3];
        end
        REQ: if (!BGn && !BRn) begin
          BRn    <= 1'b1;
          BGACKn <= 1'b0;
        end
        RD: if (step) sel_byte <= run_hi ? dma_din[15:8] : dma_din[7:0];
        WR: if (step && !full) count <= count + CW'(1);
        NXT: begin
          idx <= idx + OBJW'(1);
          if (last_idx && !last_lvl)
            level <= run_descend ? level - LVLW'(1) : level + LVLW'(1);
        end
        TERM: if (full || step) begin
          BGACKn <= 1'b1;
          done_r <= 1'b1;
          if (run_irqen) irqn <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtriders_objsort.sv
// Randomized bench: a sort-based reference model fills a scoreboard queue with the
// expected DST writes; a bus monitor pops and compares every committed write.
module tb_jtriders_objsort;
  logic        clk = 1'b0, rstn = 1'b0, cen = 1'b1, cs = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [1:0]  dsn = 2'b11;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        irqn, BRn, BGACKn, dma_we;
  logic        BGn = 1'b1, bus_busy = 1'b0;
  logic [22:0] dma_addr;
  logic [15:0] dma_din, dma_dout;
  logic [1:0]  dma_dsn;

  int n_chk = 0, n_fail = 0;
  logic [15:0] mem  [0:4095];
  logic [15:0] wmem [0:4095];
  logic [38:0] exp_q[$];
  bit stall_mode = 1'b0, grant_en = 1'b1;

  jtriders_objsort dut (
    .clk(clk), .rstn(rstn), .cen(cen), .cs(cs), .we(we), .addr(addr), .dsn(dsn), .din(din),
    .dout(dout), .irqn(irqn), .BRn(BRn), .BGn(BGn), .BGACKn(BGACKn), .dma_addr(dma_addr),
    .dma_din(dma_din), .dma_dout(dma_dout), .dma_we(dma_we), .dma_dsn(dma_dsn),
    .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;
  assign dma_din = mem[dma_addr[11:0]];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] ev);
    n_chk++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, ev);
    end
  endfunction

  // bus-side driver: cen/bus_busy pattern and a simple grant arbiter
  initial forever begin
    @(posedge clk); #1;
    cen      = stall_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
    bus_busy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    BGn      = !(grant_en && !BRn);
  end

  // monitor: inputs settle at posedge+1, so negedge sees what the next edge samples
  logic        prev_stall = 1'b0, p_we;
  logic [22:0] p_addr;
  logic [15:0] p_dout;
  logic [1:0]  p_dsn;
  logic [38:0] e;
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_ctl", {8'b0, p_we, p_dsn, dma_addr}, {8'b0, dma_we, dma_dsn, p_addr});
      check("stall_dout", 32'(dma_dout), 32'(p_dout));
    end
    prev_stall = rstn && (dma_we || dma_dsn != 2'b11) && (!cen || bus_busy);
    p_we = dma_we; p_dsn = dma_dsn; p_addr = dma_addr; p_dout = dma_dout;
    if (rstn && dma_we && cen && !bus_busy) begin
      wmem[dma_addr[11:0]] = dma_dout;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", dma_addr, dma_dout);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(dma_addr), 32'(e[38:16]));
        check("wr_data", 32'(dma_dout), 32'(e[15:0]));
      end
    end
  end

  task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] ds);
    @(posedge clk); #2; cs = 1'b1; we = 1'b1; addr = a; din = d; dsn = ds;
    @(posedge clk); #2; cs = 1'b0; we = 1'b0; dsn = 2'b11;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
    @(posedge clk); #2; cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #2; cs = 1'b0; d = dout;
  endtask

  // mode 0: idx&7, 1: random 0..11, 2: onehot pair, 3: descend pair, 4: random bytes
  task automatic load_objs(input int mode, input logic [2:0] off, input bit hi);
    logic [11:0] a; logic [15:0] w; logic [7:0] b;
    for (int i = 0; i < 128; i++) begin
      a = 12'(32'h800 + i * 8 + int'(off));
      w = 16'($urandom);
      case (mode)
        0: b = 8'(i & 7);
        1: b = 8'($urandom_range(0, 11));
        2: b = (i == 5) ? 8'h04 : (i == 2) ? 8'h01 : 8'h00;
        3: b = (i == 3) ? 8'h07 : (i == 9) ? 8'h00 : 8'h55;
        default: b = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7))
                                                 : 8'($urandom_range(0, 255));
      endcase
      if (hi) w[15:8] = b; else w[7:0] = b;
      mem[a] = w;
    end
  endtask

  // reference: rank each object by its priority level, stable-sort, emit list
  task automatic build_exp(input bit oh, input bit desc, input logic [2:0] off, input bit hi,
                           input logic [15:0] dst, output int cnt);
    int keys[$]; logic [15:0] w; logic [7:0] b; int lvl;
    for (int i = 0; i < 128; i++) begin
      w = mem[12'(32'h800 + i * 8 + int'(off))];
      b = hi ? w[15:8] : w[7:0];
      lvl = -1;
      if (!oh) begin
        if (b < 8'd8) lvl = int'(b);
      end else begin
        for (int l = 0; l < 8; l++) if (b == 8'(1 << l)) lvl = l;
      end
      if (lvl >= 0) keys.push_back((desc ? 7 - lvl : lvl) * 256 + i);
    end
    keys.sort();
    foreach (keys[n]) exp_q.push_back({23'(dst) + 23'(n), 16'(keys[n] % 256)});
    if (keys.size() < 128) exp_q.push_back({23'(dst) + 23'(keys.size()), 16'hFFFF});
    cnt = keys.size();
  endtask

  task automatic start_run(input bit oh, input bit desc, input bit irqen, input logic [2:0] off,
                           input bit hi, input bit wr_dst, input logic [15:0] dst, output int cnt);
    cpu_wr(3'd1, 16'h0100, 2'b00);
    cpu_wr(3'd3, {7'b0, hi, 5'b0, off}, 2'b00);
    if (wr_dst) cpu_wr(3'd2, dst, 2'b00);
    build_exp(oh, desc, off, hi, dst, cnt);
    cpu_wr(3'd0, {12'b0, irqen, desc, oh, 1'b1}, 2'b00);
  endtask

  task automatic finish_run(input string nm, input int cnt, input bit irqen);
    logic [15:0] rv; int n; bit seen;
    n = 0; seen = 1'b0;
    while (n < 40000) begin
      @(negedge clk); n++;
      if (!BGACKn) seen = 1'b1;
      else if (seen) break;
    end
    n_chk++;
    if (n >= 40000) begin
      n_fail++;
      $display("FAIL %s timeout: got no completion expected done within 40000 cycles", nm);
    end
    repeat (2) @(negedge clk);
    check({nm, " pending"}, exp_q.size(), 0);
    check({nm, " irqn"}, 32'(irqn), irqen ? 32'd0 : 32'd1);
    cpu_rd(3'd0, rv);
    check({nm, " status"}, 32'(rv), 32'(16'h4000 | 16'(cnt)));
    check({nm, " irqn_clr"}, 32'(irqn), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] rv; int cnt, n;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_BRn", 32'(BRn), 32'd1);
    check("rst_BGACKn", 32'(BGACKn), 32'd1);
    check("rst_irqn", 32'(irqn), 32'd1);
    check("rst_bus", {7'b0, dma_we, dma_dsn, dma_addr}, {7'b0, 1'b0, 2'b11, 23'h0});
    check("rst_dout", 32'(dout), 32'd0);
    @(posedge clk); #2; rstn = 1'b1;
    cpu_rd(3'd0, rv); check("rst_status", 32'(rv), 32'd0);
    cpu_rd(3'd3, rv); check("rst_field", 32'(rv), 32'd0);
    cpu_rd(3'd5, rv); check("rd_unmapped", 32'(rv), 32'hFFFF);
    cpu_wr(3'd1, 16'hABCD, 2'b00);
    cpu_wr(3'd1, 16'h1234, 2'b10);
    cpu_rd(3'd1, rv); check("byte_gate", 32'(rv), 32'hAB34);

    // binary ascend over idx&7, irq enabled: full list, no terminator
    load_objs(0, 3'd2, 1'b0);
    start_run(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0C00, cnt);
    finish_run("asc", cnt, 1'b1);

    // random priorities in the high byte, some out of range
    load_objs(1, 3'd5, 1'b1);
    start_run(1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 16'h0C00, cnt);
    finish_run("rand_hi", cnt, 1'b0);

    // onehot pair; a restart and a DST write mid-run must not disturb this run
    load_objs(2, 3'd0, 1'b0);
    start_run(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0C00, cnt);
    repeat (20) @(negedge clk);
    cpu_wr(3'd0, 16'h0003, 2'b00);
    cpu_wr(3'd2, 16'h0D00, 2'b00);
    finish_run("onehot", cnt, 1'b0);

    // descend uses the DST written during the previous run
    cpu_rd(3'd2, rv); check("dst_stored", 32'(rv), 32'h0D00);
    load_objs(3, 3'd1, 1'b0);
    start_run(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'h0D00, cnt);
    finish_run("descend", cnt, 1'b0);

    // bus grant withheld: request stays up, no bus activity
    grant_en = 1'b0;
    load_objs(4, 3'd7, 1'b0);
    start_run(1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 16'h0D00, cnt);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("grant_hold", {27'b0, BRn, BGACKn, dma_we, dma_dsn}, {27'b0, 5'b01011});
    end
    grant_en = 1'b1;
    finish_run("grant", cnt, 1'b0);

    // random stalls on cen/bus_busy: same result as the unstalled ascend run
    stall_mode = 1'b1;
    load_objs(0, 3'd2, 1'b0);
    start_run(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0C00, cnt);
    finish_run("stall", cnt, 1'b1);
    stall_mode = 1'b0;
    for (int k = 0; k < 128; k++)
      check("dst_mem", 32'(wmem[12'(32'hC00 + k)]), 32'((k % 16) * 8 + k / 16));

    // reset while a write is presented
    start_run(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0C00, cnt);
    n = 0;
    while (n < 2000 && !dma_we) begin @(posedge clk); #2; n++; end
    check("reach_wr", 32'(dma_we), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_BGACKn", 32'(BGACKn), 32'd1);
    check("mid_rst_bus", {6'b0, BRn, dma_we, dma_dsn, dma_addr}, {6'b0, 1'b1, 1'b0, 2'b11, 23'h0});
    #1; rstn = 1'b1;
    exp_q.delete();
    cpu_rd(3'd0, rv); check("mid_rst_status", 32'(rv), 32'd0);
    cpu_rd(3'd2, rv); check("mid_rst_dst", 32'(rv), 32'd0);
    load_objs(2, 3'd4, 1'b1);
    start_run(1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 16'h0C40, cnt);
    finish_run("restart", cnt, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
